// File: rtl/uart_frame_writer.sv
// uart_frame_writer
// Turns a stream of UART bytes into register writes. Each frame is made of
// ADDR_BYTES address bytes, then DATA_BYTES data bytes, then an optional XOR
// checksum byte. All multi-byte fields arrive MSB first. A SYNC_BYTE seen
// while the address or data is being received throws the partial frame away.
// The checksum byte itself may take any value, SYNC_BYTE included.
// Every accepted frame gives one single-cycle write_enable pulse. addr and
// data_out change only at that commit.
module uart_frame_writer #(
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned CHECK_EN   = 0,
  parameter logic [7:0]  SYNC_BYTE  = 8'hFF
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    data_rdy,
  input  logic [7:0]              data_in,
  output logic                    write_enable,
  output logic [8*ADDR_BYTES-1:0] addr,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    frame_err,
  output logic [7:0]              err_cnt,
  output logic                    busy
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;

  // Index of the final byte in each field. idx never needs more than 2 bits,
  // because both fields are at most 4 bytes long.
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    ST_ADDR = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK  = 2'd2
  } state_t;

  state_t          state_q,   state_d;
  logic   [1:0]    idx_q,     idx_d;
  logic   [AW-1:0] addr_sh_q, addr_sh_d;
  logic   [DW-1:0] data_sh_q, data_sh_d;
  logic   [7:0]    xor_q,     xor_d;
  logic   [AW-1:0] addr_q,    addr_d;
  logic   [DW-1:0] data_q,    data_d;
  logic            we_q,      we_d;
  logic            fe_q,      fe_d;
  logic   [7:0]    err_cnt_q, err_cnt_d;
  logic            rdy_q;
  logic            byte_ev;
  logic            is_sync;

  // A byte is new only on the rising edge of data_rdy. rdy_q resets high, so
  // a data_rdy that is already high when reset is released is not counted.
  assign byte_ev = data_rdy & ~rdy_q;
  assign is_sync = (data_in == SYNC_BYTE);

  // Next-state and output logic for the frame decoder.
  always_comb begin
    // NOTE: every signal gets its default value first. Then no branch can
    // leave a value unassigned, and no latch is inferred.
    state_d   = state_q;
    idx_d     = idx_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    xor_d     = xor_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    fe_d      = 1'b0;
    err_cnt_d = err_cnt_q;

    if (byte_ev) begin
      unique case (state_q)
        ST_ADDR: begin
          if (is_sync) begin
            idx_d = 2'd0;
            xor_d = 8'h00;
          end else begin
            addr_sh_d = (addr_sh_q << 8) | AW'(data_in);
            xor_d     = xor_q ^ data_in;
            if (idx_q == ADDR_LAST) begin
              state_d = ST_DATA;
              idx_d   = 2'd0;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end

        ST_DATA: begin
          if (is_sync) begin
            state_d = ST_ADDR;
            idx_d   = 2'd0;
            xor_d   = 8'h00;
          end else begin
            data_sh_d = (data_sh_q << 8) | DW'(data_in);
            xor_d     = xor_q ^ data_in;
            if (idx_q == DATA_LAST) begin
              idx_d = 2'd0;
              if (CHECK_EN != 0) begin
                state_d = ST_CHK;
              end else begin
                // Commit directly. The last data byte is taken from the
                // shift result, because the shadow register has not yet
                // been updated with it.
                state_d = ST_ADDR;
                xor_d   = 8'h00;
                addr_d  = addr_sh_q;
                data_d  = data_sh_d;
                we_d    = 1'b1;
              end
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end
        end

        ST_CHK: begin
          // SYNC_BYTE has no special meaning here; it is an ordinary checksum value.
          if (data_in == xor_q) begin
            addr_d = addr_sh_q;
            data_d = data_sh_q;
            we_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
          state_d = ST_ADDR;
          idx_d   = 2'd0;
          xor_d   = 8'h00;
        end

        default: begin
          state_d = ST_ADDR;
          idx_d   = 2'd0;
          xor_d   = 8'h00;
        end
      endcase
    end
  end

  // State register. Reset throws away any partial frame.
  always_ff @(posedge clk_in or posedge reset) begin
    // NOTE: non-blocking assignments make every register take its value from
    // the same pre-edge snapshot. With blocking assignments the result would
    // depend on the order of the statements.
    if (reset) begin
      state_q   <= ST_ADDR;
      idx_q     <= 2'd0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      xor_q     <= 8'h00;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      fe_q      <= 1'b0;
      err_cnt_q <= 8'h00;
      rdy_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      xor_q     <= xor_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      fe_q      <= fe_d;
      err_cnt_q <= err_cnt_d;
      rdy_q     <= data_rdy;
    end
  end

  assign write_enable = we_q;
  assign addr         = addr_q;
  assign data_out     = data_q;
  assign frame_err    = fe_q;
  assign err_cnt      = err_cnt_q;
  assign busy         = (state_q != ST_ADDR) | (idx_q != 2'd0);

endmodule

// File: tb/tb_uart_frame_writer.sv
// Testbench for uart_frame_writer. Four instances with different frame
// formats all receive the same byte stream. Each instance is compared, every
// cycle, against a frame-level reference model that collects the bytes of
// the current frame and decides how the frame ends.
module tb_uart_frame_writer;

  localparam int NI = 4;
  localparam int AB [NI] = '{1, 2, 1, 2};
  localparam int DB [NI] = '{1, 2, 1, 2};
  localparam int CE [NI] = '{0, 0, 1, 1};

  logic       clk_in = 1'b0;
  logic       reset;
  logic       data_rdy;
  logic [7:0] data_in;

  always #5 clk_in = ~clk_in;

  logic        a_we, b_we, c_we, d_we;
  logic        a_fe, b_fe, c_fe, d_fe;
  logic        a_busy, b_busy, c_busy, d_busy;
  logic [7:0]  a_err, b_err, c_err, d_err;
  logic [7:0]  a_addr, c_addr, a_data, c_data;
  logic [15:0] b_addr, d_addr, b_data, d_data;

  uart_frame_writer #(.ADDR_BYTES(1), .DATA_BYTES(1), .CHECK_EN(0)) dut_a (
    .clk_in(clk_in), .reset(reset), .data_rdy(data_rdy), .data_in(data_in),
    .write_enable(a_we), .addr(a_addr), .data_out(a_data),
    .frame_err(a_fe), .err_cnt(a_err), .busy(a_busy));
  uart_frame_writer #(.ADDR_BYTES(2), .DATA_BYTES(2), .CHECK_EN(0)) dut_b (
    .clk_in(clk_in), .reset(reset), .data_rdy(data_rdy), .data_in(data_in),
    .write_enable(b_we), .addr(b_addr), .data_out(b_data),
    .frame_err(b_fe), .err_cnt(b_err), .busy(b_busy));
  uart_frame_writer #(.ADDR_BYTES(1), .DATA_BYTES(1), .CHECK_EN(1)) dut_c (
    .clk_in(clk_in), .reset(reset), .data_rdy(data_rdy), .data_in(data_in),
    .write_enable(c_we), .addr(c_addr), .data_out(c_data),
    .frame_err(c_fe), .err_cnt(c_err), .busy(c_busy));
  uart_frame_writer #(.ADDR_BYTES(2), .DATA_BYTES(2), .CHECK_EN(1)) dut_d (
    .clk_in(clk_in), .reset(reset), .data_rdy(data_rdy), .data_in(data_in),
    .write_enable(d_we), .addr(d_addr), .data_out(d_data),
    .frame_err(d_fe), .err_cnt(d_err), .busy(d_busy));

  logic [31:0] o_addr [NI];
  logic [31:0] o_data [NI];
  logic [7:0]  o_err  [NI];
  logic        o_we   [NI];
  logic        o_fe   [NI];
  logic        o_busy [NI];

  assign o_addr[0] = {24'h0, a_addr};
  assign o_addr[1] = {16'h0, b_addr};
  assign o_addr[2] = {24'h0, c_addr};
  assign o_addr[3] = {16'h0, d_addr};
  assign o_data[0] = {24'h0, a_data};
  assign o_data[1] = {16'h0, b_data};
  assign o_data[2] = {24'h0, c_data};
  assign o_data[3] = {16'h0, d_data};
  assign o_err[0] = a_err;
  assign o_err[1] = b_err;
  assign o_err[2] = c_err;
  assign o_err[3] = d_err;
  assign o_we[0] = a_we;
  assign o_we[1] = b_we;
  assign o_we[2] = c_we;
  assign o_we[3] = d_we;
  assign o_fe[0] = a_fe;
  assign o_fe[1] = b_fe;
  assign o_fe[2] = c_fe;
  assign o_fe[3] = d_fe;
  assign o_busy[0] = a_busy;
  assign o_busy[1] = b_busy;
  assign o_busy[2] = c_busy;
  assign o_busy[3] = d_busy;

  int checks = 0;
  int errors = 0;

  // Reference model: the bytes of the current frame, plus the expected outputs.
  logic [7:0]  fbuf    [NI][9];
  int          flen    [NI];
  logic [31:0] exp_addr[NI];
  logic [31:0] exp_data[NI];
  int          exp_err [NI];
  logic        exp_we  [NI];
  logic        exp_fe  [NI];
  int          we_cnt  [NI];
  int          fe_cnt  [NI];
  logic        last_rdy;

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      flen[k] = 0;
      exp_addr[k] = 0;
      exp_data[k] = 0;
      exp_err[k] = 0;
      exp_we[k] = 1'b0;
      exp_fe[k] = 1'b0;
    end
  endtask

  task automatic model_event(input logic [7:0] b);
    for (int k = 0; k < NI; k++) begin
      int n;
      n = AB[k] + DB[k];
      if (flen[k] < n && b == 8'hFF) begin
        flen[k] = 0;
      end else begin
        fbuf[k][flen[k]] = b;
        flen[k]++;
        if (flen[k] == n + CE[k]) begin
          logic [7:0] x;
          x = 8'h00;
          for (int i = 0; i < n; i++) x ^= fbuf[k][i];
          if (CE[k] == 0 || fbuf[k][n] == x) begin
            exp_addr[k] = 0;
            exp_data[k] = 0;
            for (int i = 0; i < AB[k]; i++) exp_addr[k] = (exp_addr[k] << 8) | 32'(fbuf[k][i]);
            for (int i = 0; i < DB[k]; i++) exp_data[k] = (exp_data[k] << 8) | 32'(fbuf[k][AB[k]+i]);
            exp_we[k] = 1'b1;
          end else begin
            exp_fe[k] = 1'b1;
            if (exp_err[k] < 255) exp_err[k]++;
          end
          flen[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NI; k++) begin
      check({tag, ".we"},   k, 32'(o_we[k]),   32'(exp_we[k]));
      check({tag, ".fe"},   k, 32'(o_fe[k]),   32'(exp_fe[k]));
      check({tag, ".addr"}, k, o_addr[k],      exp_addr[k]);
      check({tag, ".data"}, k, o_data[k],      exp_data[k]);
      check({tag, ".err"},  k, 32'(o_err[k]),  32'(exp_err[k]));
      check({tag, ".busy"}, k, 32'(o_busy[k]), 32'(flen[k] != 0));
    end
  endtask

  // Called once for every clock edge while reset is low.
  task automatic tick(input string tag);
    logic ev;
    @(posedge clk_in);
    ev = data_rdy && !last_rdy;
    last_rdy = data_rdy;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_we[k] = 1'b0;
      exp_fe[k] = 1'b0;
    end
    if (ev) model_event(data_in);
    for (int k = 0; k < NI; k++) begin
      if (o_we[k]) we_cnt[k]++;
      if (o_fe[k]) fe_cnt[k]++;
    end
    check_all(tag);
  endtask

  task automatic cyc(input logic rdy, input logic [7:0] b, input string tag);
    @(negedge clk_in);
    data_rdy = rdy;
    data_in = b;
    tick(tag);
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap, input string tag);
    repeat (hold) cyc(1'b1, b, tag);
    repeat (gap) cyc(1'b0, b, tag);
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NI; k++) begin
      we_cnt[k] = 0;
      fe_cnt[k] = 0;
    end
  endtask

  // Assert reset away from a clock edge. The outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk_in);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    last_rdy = 1'b1;
    check_all(tag);
    @(negedge clk_in);
    reset = 1'b0;
    clear_counts();
  endtask

  initial begin
    reset = 1'b1;
    data_rdy = 1'b0;
    data_in = 8'h00;
    last_rdy = 1'b1;
    model_reset();
    clear_counts();
    #3;
    check_all("por");
    @(negedge clk_in);
    reset = 1'b0;
    cyc(1'b0, 8'h00, "idle");

    // One write with the default frame format.
    cyc(1'b1, 8'h12, "d1");
    check("d1_busy_mid", 0, 32'(o_busy[0]), 32'd1);
    cyc(1'b0, 8'h12, "d1");
    send(8'hA5, 1, 2, "d1");
    check("d1_addr", 0, o_addr[0], 32'h12);
    check("d1_data", 0, o_data[0], 32'hA5);
    check("d1_pulses", 0, 32'(we_cnt[0]), 32'd1);

    // 2+2 format: only the fourth byte gives a write.
    do_reset("r2");
    cyc(1'b0, 8'h00, "idle");
    send(8'h01, 1, 1, "d2");
    send(8'h02, 1, 1, "d2");
    send(8'hBE, 1, 1, "d2");
    check("d2_nopulse", 1, 32'(we_cnt[1]), 32'd0);
    send(8'hEF, 1, 2, "d2");
    check("d2_addr", 1, o_addr[1], 32'h0102);
    check("d2_data", 1, o_data[1], 32'hBEEF);
    check("d2_pulses", 1, 32'(we_cnt[1]), 32'd1);

    // A sync byte drops the partial frame. addr and data_out keep their values.
    do_reset("r3");
    cyc(1'b0, 8'h00, "idle");
    send(8'h12, 1, 1, "d3");
    send(8'hA5, 1, 1, "d3");
    send(8'h33, 1, 1, "d3");
    send(8'hFF, 1, 1, "d3");
    check("d3_hold_addr", 0, o_addr[0], 32'h12);
    check("d3_hold_data", 0, o_data[0], 32'hA5);
    send(8'h10, 1, 1, "d3");
    send(8'h20, 1, 2, "d3");
    check("d3_addr", 0, o_addr[0], 32'h10);
    check("d3_data", 0, o_data[0], 32'h20);
    check("d3_pulses", 0, 32'(we_cnt[0]), 32'd2);

    // Checksum: one good frame, then one bad frame.
    do_reset("r4");
    cyc(1'b0, 8'h00, "idle");
    send(8'h05, 1, 1, "d4");
    send(8'h0A, 1, 1, "d4");
    send(8'h0F, 1, 2, "d4");
    check("d4_addr", 2, o_addr[2], 32'h05);
    check("d4_data", 2, o_data[2], 32'h0A);
    send(8'h05, 1, 1, "d4");
    send(8'h0A, 1, 1, "d4");
    send(8'h00, 1, 2, "d4");
    check("d4_pulses", 2, 32'(we_cnt[2]), 32'd1);
    check("d4_fe_pulses", 2, 32'(fe_cnt[2]), 32'd1);
    check("d4_errcnt", 2, 32'(o_err[2]), 32'd1);
    check("d4_keep_addr", 2, o_addr[2], 32'h05);

    // data_rdy is already high when reset is released, then each byte is held for 10 cycles.
    data_rdy = 1'b1;
    data_in = 8'h77;
    do_reset("r5");
    repeat (5) cyc(1'b1, 8'h77, "d5_rel");
    check("d5_no_event", 0, 32'(o_busy[0]), 32'd0);
    cyc(1'b0, 8'h77, "d5");
    send(8'h12, 10, 1, "d5");
    send(8'hA5, 10, 2, "d5");
    check("d5_pulses", 0, 32'(we_cnt[0]), 32'd1);
    check("d5_addr", 0, o_addr[0], 32'h12);

    // Reset in the middle of a frame, then one complete 2+2 frame.
    send(8'h01, 1, 1, "d6");
    do_reset("r6");
    check("d6_rst_busy", 1, 32'(o_busy[1]), 32'd0);
    cyc(1'b0, 8'h00, "idle");
    send(8'h11, 1, 1, "d6");
    send(8'h22, 1, 1, "d6");
    send(8'h33, 1, 1, "d6");
    send(8'h44, 1, 2, "d6");
    check("d6_addr", 1, o_addr[1], 32'h1122);
    check("d6_data", 1, o_data[1], 32'h3344);

    // Random stream. When an instance is at its checksum byte, the stream
    // often supplies the correct checksum.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      int r;
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r == 0) begin
        b = 8'hFF;
      end else if (r < 4 && flen[3] == 4) begin
        b = fbuf[3][0] ^ fbuf[3][1] ^ fbuf[3][2] ^ fbuf[3][3];
      end else if (r < 7 && flen[2] == 2) begin
        b = fbuf[2][0] ^ fbuf[2][1];
      end
      send(b, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), "rnd");
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
        cyc(1'b0, 8'h00, "idle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
